// File: rtl/popcount_frame_acc_if.sv
// Stream bundle for popcount_frame_acc: word input channel and frame-result output channel.
// slave is the accumulator side, master is the producer/consumer side.
interface popcount_frame_acc_if #(
    parameter int DATA_W = 10,
    parameter int ACC_W  = 16,
    parameter int LEN_W  = 8
) ();
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;
    logic              s_last;
    logic              m_valid;
    logic              m_ready;
    logic [ACC_W-1:0]  m_count;
    logic [LEN_W-1:0]  m_len;
    logic              m_sat;

    modport slave (
        input  s_valid, s_data, s_last, m_ready,
        output s_ready, m_valid, m_count, m_len, m_sat
    );

    modport master (
        output s_valid, s_data, s_last, m_ready,
        input  s_ready, m_valid, m_count, m_len, m_sat
    );
endinterface

// File: rtl/popcount_frame_acc.sv
// Counts set bits across a frame of words and emits one saturating result per frame
// (bit total, word count, saturation flag) with single-cycle latency on the last word.
module popcount_frame_acc #(
    parameter int DATA_W = 10,
    parameter int ACC_W  = 16,
    parameter int LEN_W  = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    popcount_frame_acc_if.slave    bus,
    output logic                   busy,
    output logic                   o_dbg_state
);
    localparam int PC_W = $clog2(DATA_W + 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_ACCUM = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_next;

    logic [ACC_W-1:0]  r_acc;
    logic [LEN_W-1:0]  r_len;
    logic              r_sat_flag;

    logic              r_m_valid;
    logic [ACC_W-1:0]  r_m_count;
    logic [LEN_W-1:0]  r_m_len;
    logic              r_m_sat;

    logic [PC_W-1:0]   w_pc;
    logic              w_s_ready;
    logic              w_accept;
    logic              w_accept_last;
    logic [ACC_W:0]    w_acc_sum;
    logic [LEN_W:0]    w_len_sum;
    logic              w_acc_ovf;
    logic              w_len_ovf;
    logic [ACC_W-1:0]  w_acc_next;
    logic [LEN_W-1:0]  w_len_next;
    logic              w_sat_next;

    always_comb begin
        w_pc = '0;
        for (int i = 0; i < DATA_W; i++) begin
            w_pc = w_pc + PC_W'(bus.s_data[i]);
        end
    end

    // Handshake: a beat transfers on a rising edge where s_valid && s_ready; a result
    // transfers where m_valid && m_ready. s_ready never looks at s_valid, and a held
    // result blocks input only while the consumer is stalling it.
    assign w_s_ready     = !r_m_valid || bus.m_ready;
    assign w_accept      = bus.s_valid && w_s_ready;
    assign w_accept_last = w_accept && bus.s_last;

    // Extra top bit catches overflow; the stored field then clamps to all-ones.
    assign w_acc_sum  = {1'b0, r_acc} + (ACC_W + 1)'(w_pc);
    assign w_len_sum  = {1'b0, r_len} + (LEN_W + 1)'(1);
    assign w_acc_ovf  = w_acc_sum[ACC_W];
    assign w_len_ovf  = w_len_sum[LEN_W];
    assign w_acc_next = w_acc_ovf ? '1 : w_acc_sum[ACC_W-1:0];
    assign w_len_next = w_len_ovf ? '1 : w_len_sum[LEN_W-1:0];
    assign w_sat_next = r_sat_flag | w_acc_ovf | w_len_ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (w_accept) begin
            w_state_next = bus.s_last ? S_IDLE : S_ACCUM;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc      <= '0;
            r_len      <= '0;
            r_sat_flag <= 1'b0;
        end else if (w_accept_last) begin
            r_acc      <= '0;
            r_len      <= '0;
            r_sat_flag <= 1'b0;
        end else if (w_accept) begin
            r_acc      <= w_acc_next;
            r_len      <= w_len_next;
            r_sat_flag <= w_sat_next;
        end
    end

    // Result registers only load on a last beat, so they hold while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m_valid <= 1'b0;
            r_m_count <= '0;
            r_m_len   <= '0;
            r_m_sat   <= 1'b0;
        end else begin
            if (w_accept_last) begin
                r_m_valid <= 1'b1;
                r_m_count <= w_acc_next;
                r_m_len   <= w_len_next;
                r_m_sat   <= w_sat_next;
            end else if (bus.m_ready) begin
                r_m_valid <= 1'b0;
            end
        end
    end

    assign bus.s_ready = w_s_ready;
    assign bus.m_valid = r_m_valid;
    assign bus.m_count = r_m_count;
    assign bus.m_len   = r_m_len;
    assign bus.m_sat   = r_m_sat;

    assign busy        = (r_state == S_ACCUM);
    assign o_dbg_state = r_state;
endmodule

// File: tb/tb_popcount_frame_acc.sv
// Bench for popcount_frame_acc: frame-level reference model with a cycle compare,
// plus directed frames with hand-worked results on a default and an ACC_W=8 instance.
module tb_popcount_frame_acc;
    localparam int DW  = 10;
    localparam int AW  = 16;
    localparam int LW  = 8;
    localparam int AW8 = 8;
    localparam int RW  = AW + LW + 1;
    localparam int MAXC = (1 << AW) - 1;
    localparam int MAXL = (1 << LW) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    popcount_frame_acc_if #(.DATA_W(DW), .ACC_W(AW),  .LEN_W(LW)) if1 ();
    popcount_frame_acc_if #(.DATA_W(DW), .ACC_W(AW8), .LEN_W(LW)) if2 ();

    logic busy1, dbg1, busy2, dbg2;

    popcount_frame_acc #(.DATA_W(DW), .ACC_W(AW), .LEN_W(LW)) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(if1.slave), .busy(busy1), .o_dbg_state(dbg1)
    );

    popcount_frame_acc #(.DATA_W(DW), .ACC_W(AW8), .LEN_W(LW)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .bus(if2.slave), .busy(busy2), .o_dbg_state(dbg2)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: words of the open frame and pending results {count,len,sat}
    logic [DW-1:0] frame_q[$];
    logic [RW-1:0] exp_q[$];

    always @(posedge clk or negedge rst_n) begin : model
        int   total;
        int   n;
        logic took;
        logic [AW-1:0] cnt;
        logic [LW-1:0] ln;
        logic sat;
        if (!rst_n) begin
            frame_q.delete();
            exp_q.delete();
        end else begin
            took = if1.s_valid && (exp_q.size() == 0 || if1.m_ready);
            if (exp_q.size() != 0 && if1.m_ready) void'(exp_q.pop_front());
            if (took) begin
                frame_q.push_back(if1.s_data);
                if (if1.s_last) begin
                    total = 0;
                    foreach (frame_q[i]) total += $countones(frame_q[i]);
                    n   = frame_q.size();
                    cnt = AW'((total > MAXC) ? MAXC : total);
                    ln  = LW'((n > MAXL) ? MAXL : n);
                    sat = (total > MAXC) || (n > MAXL);
                    exp_q.push_back({cnt, ln, sat});
                    frame_q.delete();
                end
            end
        end
    end

    always @(negedge clk) begin : compare
        logic [RW-1:0] e;
        chk("s_ready", if1.s_ready, (exp_q.size() == 0) || if1.m_ready);
        chk("m_valid", if1.m_valid, exp_q.size() != 0);
        chk("busy", busy1, frame_q.size() != 0);
        if (exp_q.size() != 0) begin
            e = exp_q[0];
            chk("m_count", if1.m_count, e[RW-1 -: AW]);
            chk("m_len", if1.m_len, e[LW:1]);
            chk("m_sat", if1.m_sat, e[0]);
        end
    end

    // Called at posedge+1 only; returns at posedge+1 after the beat is taken.
    task automatic send(input logic [DW-1:0] d, input logic last);
        logic took;
        int   guard;
        if1.s_valid = 1'b1;
        if1.s_data  = d;
        if1.s_last  = last;
        took  = 1'b0;
        guard = 0;
        while (!took && guard < 50) begin
            @(negedge clk);
            took = if1.s_ready;
            @(posedge clk);
            #1;
            guard++;
        end
        if (!took) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle1();
        if1.s_valid = 1'b0;
        if1.s_last  = 1'b0;
        if1.s_data  = '0;
    endtask

    task automatic chk_res(input string name, input int c, input int l, input int s);
        chk({name, "_valid"}, if1.m_valid, 32'd1);
        chk({name, "_count"}, if1.m_count, c);
        chk({name, "_len"}, if1.m_len, l);
        chk({name, "_sat"}, if1.m_sat, s);
    endtask

    initial begin
        idle1();
        if1.m_ready = 1'b1;
        if2.s_valid = 1'b0;
        if2.s_data  = '0;
        if2.s_last  = 1'b0;
        if2.m_ready = 1'b1;

        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        chk("rst_m_valid", if1.m_valid, 32'd0);
        chk("rst_m_count", if1.m_count, 32'd0);
        chk("rst_m_len", if1.m_len, 32'd0);
        chk("rst_m_sat", if1.m_sat, 32'd0);
        chk("rst_busy", busy1, 32'd0);
        chk("rst_s_ready", if1.s_ready, 32'd1);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 10 + 1 + 0 set bits over three words
        send(10'h3FF, 1'b0);
        chk("mid_busy", busy1, 32'd1);
        send(10'h001, 1'b0);
        send(10'h000, 1'b1);
        idle1();
        chk_res("f3", 11, 3, 0);
        @(posedge clk);
        #1;
        chk("f3_valid_drop", if1.m_valid, 32'd0);

        // single word under backpressure, then release with a waiting last beat
        if1.m_ready = 1'b0;
        send(10'h2AA, 1'b1);
        chk_res("one", 5, 1, 0);
        if1.s_data = 10'h0FF;
        repeat (3) begin
            @(negedge clk);
            chk("stall_s_ready", if1.s_ready, 32'd0);
            chk("stall_count", if1.m_count, 32'd5);
            chk("stall_len", if1.m_len, 32'd1);
        end
        #2 if1.m_ready = 1'b1;
        #1 chk("release_s_ready", if1.s_ready, 32'd1);
        @(posedge clk);
        #1;
        idle1();
        chk_res("nobubble", 8, 1, 0);
        @(posedge clk);
        #1;
        chk("nobubble_drop", if1.m_valid, 32'd0);

        // back-to-back single-word frames
        send(10'h001, 1'b1);
        chk_res("b2b1", 1, 1, 0);
        send(10'h003, 1'b1);
        chk_res("b2b2", 2, 1, 0);
        send(10'h007, 1'b1);
        chk_res("b2b3", 3, 1, 0);
        idle1();
        @(posedge clk);
        #1;

        // zero-valued words still count as words
        send(10'h000, 1'b0);
        send(10'h000, 1'b1);
        idle1();
        chk_res("zeros", 0, 2, 0);

        // 256 words overflow the 8-bit length
        for (int i = 0; i < 256; i++) send(10'h001, i == 255);
        idle1();
        chk_res("lensat", 256, 255, 1);
        @(posedge clk);
        #1;

        // reset mid-frame drops the partial frame
        send(10'h3FF, 1'b0);
        send(10'h155, 1'b0);
        idle1();
        chk("pre_rst_busy", busy1, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy1, 32'd0);
        chk("midrst_valid", if1.m_valid, 32'd0);
        chk("midrst_count", if1.m_count, 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(10'h00F, 1'b1);
        idle1();
        chk_res("after_rst", 4, 1, 0);
        @(posedge clk);
        #1;

        // ACC_W=8: 26 x 10 bits = 260 clamps to 255
        for (int i = 0; i < 26; i++) begin
            if2.s_valid = 1'b1;
            if2.s_data  = 10'h3FF;
            if2.s_last  = (i == 25);
            @(negedge clk);
            chk("w8_s_ready", if2.s_ready, 32'd1);
            if (i == 25) chk("w8_busy", busy2, 32'd1);
            @(posedge clk);
            #1;
        end
        if2.s_valid = 1'b0;
        if2.s_last  = 1'b0;
        chk("w8_valid", if2.m_valid, 32'd1);
        chk("w8_count", if2.m_count, 32'd255);
        chk("w8_len", if2.m_len, 32'd26);
        chk("w8_sat", if2.m_sat, 32'd1);
        chk("w8_idle", busy2, 32'd0);

        // the following frame starts with a clean saturation flag
        if2.s_valid = 1'b1;
        if2.s_data  = 10'h3FF;
        if2.s_last  = 1'b1;
        @(posedge clk);
        #1;
        if2.s_valid = 1'b0;
        if2.s_last  = 1'b0;
        chk("w8_next_count", if2.m_count, 32'd10);
        chk("w8_next_len", if2.m_len, 32'd1);
        chk("w8_next_sat", if2.m_sat, 32'd0);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/popcount_frame_acc.md
POPCOUNT_FRAME_ACC -- requirements
Module: popcount_frame_acc

Interface
REQ-001 SHALL have parameter DATA_W, default 10, giving the input word width in bits.
REQ-002 SHALL have parameter ACC_W, default 16, giving the frame bit-count accumulator and result width.
REQ-003 SHALL have parameter LEN_W, default 8, giving the frame word-count width.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 s_valid  input  1  input word valid.
REQ-007 s_ready  output  1  block can accept a word this cycle.
REQ-008 s_data  input  DATA_W  input word whose set bits are counted.
REQ-009 s_last  input  1  final word of the current frame.
REQ-010 m_valid  output  1  frame result valid.
REQ-011 m_ready  input  1  downstream accepts the result.
REQ-012 m_count  output  ACC_W  total set bits in the frame, saturating.
REQ-013 m_len  output  LEN_W  words in the frame, saturating.
REQ-014 m_sat  output  1  m_count or m_len saturated in this frame.
REQ-015 busy  output  1  a frame is partially accumulated (state ACCUM).

Function
REQ-016 Per-word count pc SHALL equal the number of ones in s_data, computed combinationally in the same cycle, width clog2(DATA_W+1).
REQ-017 s_ready SHALL be (!m_valid || m_ready), purely combinational; no dependence on s_valid.
REQ-018 A beat SHALL be accepted only when s_valid && s_ready on a rising edge; s_data and s_last are ignored otherwise.
REQ-019 FSM states SHALL be IDLE (acc=0, len=0) and ACCUM (partial frame held); busy=1 only in ACCUM.
REQ-020 An accepted non-last beat SHALL set acc<=sat(acc+pc) and len<=sat(len+1), OR sticky sat_flag on overflow, and go to ACCUM.
REQ-021 An accepted last beat SHALL load m_count<=sat(acc+pc), m_len<=sat(len+1), m_sat<=sat_flag|new overflow, set m_valid, clear acc/len/sat_flag, and go to IDLE.
REQ-022 Latency SHALL be one cycle: m_valid rises on the edge that accepts the last beat.
REQ-023 Saturation SHALL clamp to all-ones of the field width; no wrap-around is permitted.
REQ-024 A single-word frame (s_last on the first beat) SHALL yield m_len=1 and m_count=pc.
REQ-025 m_count, m_len and m_sat SHALL hold stable while m_valid && !m_ready.
REQ-026 m_valid SHALL clear on an edge with m_valid && m_ready, unless a last beat is accepted on the same edge, in which case it stays 1 and the new result loads.
REQ-027 Simultaneous m_ready and accepted beats SHALL give zero-bubble throughput: one word per cycle, and back-to-back single-word frames, sustained.
REQ-028 A zero-valued word SHALL still increment len.

Reset
REQ-029 On rst_n low, m_valid=0, m_count=0, m_len=0, m_sat=0, busy=0, acc=0, len=0, sat_flag=0, and state=IDLE, all immediately and without a clock.
REQ-030 s_ready SHALL read 1 during and after reset, following REQ-017.
REQ-031 Reset asserted mid-frame SHALL discard the partial frame; no result is emitted for it.
REQ-032 Deassertion SHALL be synchronised externally; the first edge after release SHALL process normally.

Verification
REQ-033 DATA_W=10, frame 0x3FF, 0x001, 0x000 (last), m_ready=1 -> m_count=11, m_len=3, m_sat=0, m_valid for 1 cycle.
REQ-034 Single word 0x2AA with last -> m_count=5, m_len=1, on the cycle after acceptance.
REQ-035 ACC_W=8, 26 words of 0x3FF, the 26th last -> m_count=255, m_len=26, m_sat=1.
REQ-036 m_ready=0 with result pending, s_valid=1 -> s_ready=0, outputs stable; raise m_ready -> same-cycle s_ready=1 and the next frame accepted with no bubble.
REQ-037 Assert rst_n=0 after 2 beats of a frame -> busy=0 and m_valid=0 immediately; a new frame 0x00F (last) -> m_count=4, m_len=1.
REQ-038 Continuous single-word frames 0x001, 0x003, 0x007 with m_ready=1 -> m_count 1, 2, 3 on consecutive cycles, m_valid held high.
